// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard for the in-order pipeline.
// Tracks in-flight register writes in a per-stage shift register and, for each
// decode source operand, picks a forward tap or requests a decode stall.
module hazard_scoreboard #(
    parameter int unsigned AW    = 5,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned LW    = 2,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  id_valid,
    input  logic                  id_flush,
    input  logic [NSRC*AW-1:0]    id_src,
    input  logic [NSRC-1:0]       id_src_used,
    input  logic [AW-1:0]         id_dst,
    input  logic                  id_dst_we,
    input  logic [LW-1:0]         id_rdy,
    output logic                  stall,
    output logic [NSRC*SEL_W-1:0] fwd_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [LW-1:0]    RDY_MAX = LW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Slot k holds the write issued k stages ago (0 = EX).
    logic [DEPTH-1:0] slot_valid;
    logic [AW-1:0]    slot_dst [DEPTH];
    logic [LW-1:0]    slot_rdy [DEPTH];

    logic             id_live;
    logic [LW-1:0]    rdy_eff;
    logic [NSRC-1:0]  stall_req;
    logic             ins_c;

    // Decode qualification, latency clamp and slot-0 insert condition.
    always_comb begin
        id_live = id_valid & ~id_flush;
        rdy_eff = (id_rdy > RDY_MAX) ? RDY_MAX : id_rdy;
        ins_c   = id_live & ~stall & id_dst_we & (id_dst != '0);
    end

    // Per-operand match: walk oldest to youngest so the youngest hit overwrites.
    always_comb begin
        stall_req = '0;
        fwd_sel   = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
                if (id_live && id_src_used[i] && slot_valid[k] &&
                    (slot_dst[k] != '0) && (slot_dst[k] == id_src[i*AW +: AW])) begin
                    if (slot_rdy[k] <= LW'(k)) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        stall_req[i]              = 1'b0;
                    end else begin
                        fwd_sel[i*SEL_W +: SEL_W] = '0;
                        stall_req[i]              = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = |stall_req;

    // Slot shift, bubble/insert into slot 0, and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot_dst[k] <= '0;
                slot_rdy[k] <= '0;
            end
            stall_cnt <= '0;
        end else if (!hold) begin
            for (int k = 1; k < int'(DEPTH); k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_dst[k]   <= slot_dst[k-1];
                slot_rdy[k]   <= slot_rdy[k-1];
            end
            slot_valid[0] <= ins_c;
            slot_dst[0]   <= ins_c ? id_dst  : '0;
            slot_rdy[0]   <= ins_c ? rdy_eff : '0;
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
